// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the memory arbiter
// Holds the arbiter state encoding, transfer size codes, requester grant
// bit positions and the load-data size mask helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Bit positions of each requester inside the one-hot grant vector.
  localparam int REQ_IF = 0;
  localparam int REQ_LD = 1;
  localparam int REQ_ST = 2;

  // Zero-extends read data to the transfer size; unknown size codes pass
  // the full word through.
  function automatic logic [31:0] size_mask(input logic [1:0] size,
                                            input logic [31:0] data);
    logic [31:0] res;
    case (size)
      SIZE_B:  res = {24'h0, data[7:0]};
      SIZE_H:  res = {16'h0, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational priority picker with starvation override
// Ports:
//   if_req, ld_req, st_req : requester levels
//   flush                  : fetch flush, removes fetch from this pick
//   starve                 : fetch has lost enough arbitrations to win next
//   grant[2:0]             : one-hot winner, bit positions REQ_IF/LD/ST
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       if_req,
  input  logic       ld_req,
  input  logic       st_req,
  input  logic       flush,
  input  logic       starve,
  output logic [2:0] grant
);

  logic if_ok;

  assign if_ok = if_req && !flush;

  always_comb begin
    grant = '0;
    if (if_ok && starve) begin
      grant[REQ_IF] = 1'b1;
    end else if (st_req) begin
      grant[REQ_ST] = 1'b1;
    end else if (ld_req) begin
      grant[REQ_LD] = 1'b1;
    end else if (if_ok) begin
      grant[REQ_IF] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory controller between fetch, load and store
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   if_req/if_addr/if_flush       : fetch request, address, flush pulse
//   if_done/if_data/if_addr_o     : fetch completion pulse, data, address
//   ld_req/ld_addr/ld_size        : load request
//   ld_done/ld_data               : load completion pulse, zero-extended data
//   st_req/st_addr/st_data/st_size: store request
//   st_done                       : store completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_size : transaction to the controller
//   mem_done/mem_rdata            : controller completion and read data
// Optional macro MEM_ARB_PERF_EN adds perf_if_cnt, perf_ld_cnt, perf_st_cnt
// (completed transactions) and perf_stall_cnt (cycles with a request pending
// while not IDLE).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_data,
  output logic [31:0] if_addr_o,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_if_cnt,
  output logic [31:0] perf_ld_cnt,
  output logic [31:0] perf_st_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  arb_state_t  state;
  arb_state_t  state_d;
  logic [2:0]  grant;
  logic [2:0]  gnt_q;
  logic [3:0]  starve_cnt;
  logic        starve;
  logic        fetch_flushed;
  logic        do_grant;
  logic        do_respond;
  logic        do_release;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic [1:0]  gnt_size;

  assign starve = (starve_cnt >= 4'(STARVE_LIMIT));

  // Only a held fetch grant reacts to flush; loads and stores run to completion.
  assign fetch_flushed = gnt_q[REQ_IF] && if_flush;

  mem_arb_pick u_pick (
    .if_req (if_req),
    .ld_req (ld_req),
    .st_req (st_req),
    .flush  (if_flush),
    .starve (starve),
    .grant  (grant)
  );

  always_comb begin
    gnt_addr  = if_addr;
    gnt_wdata = '0;
    gnt_size  = SIZE_W;
    if (grant[REQ_ST]) begin
      gnt_addr  = st_addr;
      gnt_wdata = st_data;
      gnt_size  = st_size;
    end else if (grant[REQ_LD]) begin
      gnt_addr  = ld_addr;
      gnt_size  = ld_size;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    do_grant   = 1'b0;
    do_respond = 1'b0;
    do_release = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|grant) begin
          do_grant = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_done) begin
          do_release = 1'b1;
          // A flush landing on the completion cycle drops the result and
          // skips the turnaround, since no requester needs to drop req.
          if (fetch_flushed) begin
            state_d = ST_IDLE;
          end else begin
            do_respond = 1'b1;
            state_d    = ST_RESP;
          end
        end else if (fetch_flushed) begin
          state_d = ST_DRAIN;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (mem_done) begin
          do_release = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      if_done   <= 1'b0;
      if_data   <= '0;
      if_addr_o <= '0;
      ld_done   <= 1'b0;
      ld_data   <= '0;
      st_done   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      ld_done <= 1'b0;
      st_done <= 1'b0;
      if (do_grant) begin
        gnt_q     <= grant;
        mem_req   <= 1'b1;
        mem_we    <= grant[REQ_ST];
        mem_addr  <= gnt_addr;
        mem_wdata <= gnt_wdata;
        mem_size  <= gnt_size;
      end
      if (do_release) begin
        mem_req <= 1'b0;
      end
      if (do_respond) begin
        if (gnt_q[REQ_IF]) begin
          if_done   <= 1'b1;
          if_data   <= mem_rdata;
          if_addr_o <= mem_addr;
        end
        if (gnt_q[REQ_LD]) begin
          ld_done <= 1'b1;
          ld_data <= size_mask(mem_size, mem_rdata);
        end
        if (gnt_q[REQ_ST]) begin
          st_done <= 1'b1;
        end
      end
    end
  end

  // Counts load/store wins taken while fetch was waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_flush) begin
      starve_cnt <= '0;
    end else if (do_grant && grant[REQ_IF]) begin
      starve_cnt <= '0;
    end else if (do_grant && if_req && (grant[REQ_LD] || grant[REQ_ST])
                 && (starve_cnt != 4'hF)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_cnt    <= '0;
      perf_ld_cnt    <= '0;
      perf_st_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (do_respond && gnt_q[REQ_IF]) perf_if_cnt <= perf_if_cnt + 32'd1;
      if (do_respond && gnt_q[REQ_LD]) perf_ld_cnt <= perf_ld_cnt + 32'd1;
      if (do_respond && gnt_q[REQ_ST]) perf_st_cnt <= perf_st_cnt + 32'd1;
      if ((if_req || ld_req || st_req) && (state != ST_IDLE)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam logic [1:0] ID_IF = 2'd0;
  localparam logic [1:0] ID_LD = 2'd1;
  localparam logic [1:0] ID_ST = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic [31:0] if_addr_o;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_done;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } issue_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic [31:0] addr;
  } resp_t;

  typedef struct {
    int          lat;
    logic        ifr;
    logic [31:0] ia;
    logic        ldr;
    logic [31:0] la;
    logic [1:0]  ls;
    logic        str;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [1:0]  ss;
    int          n;
    logic [5:0]  ord;
    logic [31:0] eif;
    logic [31:0] eld;
  } vec_t;

  issue_t issue_q[$];
  resp_t  resp_q[$];
  vec_t   vecs[9];
  int     n_checks = 0;
  int     n_fail = 0;
  int     mem_lat = 3;

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_done   (if_done),
    .if_data   (if_data),
    .if_addr_o (if_addr_o),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_size   (ld_size),
    .ld_done   (ld_done),
    .ld_data   (ld_data),
    .st_req    (st_req),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .st_done   (st_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_size  (mem_size),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && mem_done) assert (mem_req);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500us");
    $fatal(1);
  end

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0000_0013;
    return a ^ 32'hC3A5_96F1;
  endfunction

  function automatic vec_t mk(input int lat, input logic ifr, input logic [31:0] ia,
                              input logic ldr, input logic [31:0] la, input logic [1:0] ls,
                              input logic str, input logic [31:0] sa, input logic [31:0] sd,
                              input logic [1:0] ss, input int n, input logic [5:0] ord,
                              input logic [31:0] eif, input logic [31:0] eld);
    vec_t v;
    v.lat = lat; v.ifr = ifr; v.ia = ia; v.ldr = ldr; v.la = la; v.ls = ls;
    v.str = str; v.sa = sa; v.sd = sd; v.ss = ss; v.n = n; v.ord = ord;
    v.eif = eif; v.eld = eld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out, expected event within bound", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_issue(input logic [1:0] id, input logic [31:0] a,
                            input logic [1:0] sz, input logic [31:0] wd);
    issue_t e;
    e.we    = (id == ID_ST);
    e.addr  = a;
    e.size  = (id == ID_IF) ? 2'd2 : sz;
    e.wdata = wd;
    issue_q.push_back(e);
  endtask

  task automatic push_resp(input logic [1:0] id, input logic [31:0] d, input logic [31:0] a);
    resp_t r;
    r.id = id; r.data = d; r.addr = a;
    resp_q.push_back(r);
  endtask

  task automatic controller();
    issue_t e;
    logic   abort;
    int     lat;
    forever begin
      tick();
      if (!rst && mem_req) begin
        if (issue_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue: got addr %h, expected no transaction", mem_addr);
          e = '{mem_we, mem_addr, mem_size, mem_wdata};
        end else begin
          e = issue_q.pop_front();
        end
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_size", 32'(mem_size), 32'(e.size));
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        lat = mem_lat;
        abort = 1'b0;
        for (int i = 1; i < lat; i++) begin
          tick();
          if (rst) begin
            abort = 1'b1;
            break;
          end
          chk("mem_addr_stable", mem_addr, e.addr);
        end
        if (!abort && !rst) begin
          mem_rdata = mem_model(e.addr);
          mem_done  = 1'b1;
          tick();
          mem_done  = 1'b0;
          mem_rdata = '0;
        end
      end
    end
  endtask

  task automatic got_resp(input logic [1:0] id, input logic [31:0] data, input logic [31:0] addr);
    resp_t e;
    if (resp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_done: got done for id %0d, expected none", id);
      return;
    end
    e = resp_q.pop_front();
    chk("done_id", 32'(id), 32'(e.id));
    if (id == ID_IF) begin
      chk("if_data", data, e.data);
      chk("if_addr_o", addr, e.addr);
    end
    if (id == ID_LD) chk("ld_data", data, e.data);
  endtask

  task automatic monitor();
    forever begin
      tick();
      if (if_done) got_resp(ID_IF, if_data, if_addr_o);
      if (ld_done) got_resp(ID_LD, ld_data, 32'h0);
      if (st_done) got_resp(ID_ST, 32'h0, 32'h0);
    end
  endtask

  task automatic wait_mem_req(input string nm);
    int c = 0;
    while (!mem_req && c < 100) begin
      tick();
      c++;
    end
    if (!mem_req) fail_now(nm);
  endtask

  task automatic apply_vec(input vec_t v);
    logic [1:0] id;
    int         remaining;
    int         cyc;
    mem_lat = v.lat;
    if_req = v.ifr; if_addr = v.ia;
    ld_req = v.ldr; ld_addr = v.la; ld_size = v.ls;
    st_req = v.str; st_addr = v.sa; st_data = v.sd; st_size = v.ss;
    for (int k = 0; k < v.n; k++) begin
      id = v.ord[2*k +: 2];
      case (id)
        ID_IF: begin push_issue(ID_IF, v.ia, 2'd2, 32'h0); push_resp(ID_IF, v.eif, v.ia); end
        ID_LD: begin push_issue(ID_LD, v.la, v.ls, 32'h0); push_resp(ID_LD, v.eld, 32'h0); end
        default: begin push_issue(ID_ST, v.sa, v.ss, v.sd); push_resp(ID_ST, 32'h0, 32'h0); end
      endcase
    end
    remaining = v.n;
    cyc = 0;
    while (remaining > 0 && cyc < 300) begin
      tick();
      cyc++;
      if (if_done) begin if_req = 1'b0; remaining--; end
      if (ld_done) begin ld_req = 1'b0; remaining--; end
      if (st_done) begin st_req = 1'b0; remaining--; end
    end
    if (remaining > 0) fail_now("vector_done");
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int cyc;
    int lds;
    vecs[0] = mk(9, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 1, {2'd0, 2'd0, ID_IF}, 32'h0000_0013, 0);
    vecs[1] = mk(3, 0, 0, 1, 32'h3000, 2'd0, 0, 0, 0, 0, 1, {2'd0, 2'd0, ID_LD}, 0, 32'h0000_00F1);
    vecs[2] = mk(3, 0, 0, 1, 32'h3002, 2'd1, 0, 0, 0, 0, 1, {2'd0, 2'd0, ID_LD}, 0, 32'h0000_A6F3);
    vecs[3] = mk(2, 0, 0, 1, 32'h4004, 2'd2, 0, 0, 0, 0, 1, {2'd0, 2'd0, ID_LD}, 0, 32'hC3A5_D6F5);
    vecs[4] = mk(3, 0, 0, 0, 0, 0, 1, 32'h2000, 32'hAABB_CCDD, 2'd2, 1, {2'd0, 2'd0, ID_ST}, 0, 0);
    vecs[5] = mk(1, 0, 0, 0, 0, 0, 1, 32'h2010, 32'h1122_3344, 2'd0, 1, {2'd0, 2'd0, ID_ST}, 0, 0);
    vecs[6] = mk(3, 0, 0, 1, 32'h3000, 2'd0, 1, 32'h2000, 32'hAABB_CCDD, 2'd2, 2,
                 {2'd0, ID_LD, ID_ST}, 0, 32'h0000_00F1);
    vecs[7] = mk(2, 1, 32'h1040, 1, 32'h3200, 2'd1, 1, 32'h2040, 32'hCAFE_F00D, 2'd1, 3,
                 {ID_IF, ID_LD, ID_ST}, 32'hC3A5_86B1, 32'h0000_A4F1);
    vecs[8] = mk(3, 1, 32'h1080, 1, 32'h3300, 2'd0, 0, 0, 0, 0, 2,
                 {2'd0, ID_IF, ID_LD}, 32'hC3A5_8671, 32'h0000_00F1);

    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0; ld_req = 0; ld_addr = 0; ld_size = 0;
    st_req = 0; st_addr = 0; st_data = 0; st_size = 0; mem_done = 0; mem_rdata = 0;
    fork
      controller();
      monitor();
    join_none

    repeat (3) tick();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_size", 32'(mem_size), 0);
    chk("rst_if_done", 32'(if_done), 0);
    chk("rst_ld_done", 32'(ld_done), 0);
    chk("rst_st_done", 32'(st_done), 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_if_addr_o", if_addr_o, 0);
    chk("rst_ld_data", ld_data, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

    // Starvation: loads keep winning until fetch has lost twice.
    mem_lat = 2;
    if_req = 1; if_addr = 32'h10C0; ld_req = 1; ld_addr = 32'h3400; ld_size = 2'd2;
    push_issue(ID_LD, 32'h3400, 2'd2, 0); push_resp(ID_LD, 32'hC3A5_A2F1, 0);
    push_issue(ID_LD, 32'h3400, 2'd2, 0); push_resp(ID_LD, 32'hC3A5_A2F1, 0);
    push_issue(ID_IF, 32'h10C0, 2'd2, 0); push_resp(ID_IF, 32'hC3A5_8631, 32'h10C0);
    cyc = 0; lds = 0;
    while (!if_done && cyc < 300) begin
      tick();
      cyc++;
      if (ld_done) lds++;
    end
    if (!if_done) fail_now("starve_if_done");
    if_req = 0; ld_req = 0;
    chk("starve_loads_before_fetch", 32'(lds), 2);
    repeat (2) tick();
    // Counter cleared by the fetch grant: load wins again.
    apply_vec(vecs[8]);

    // Flush two cycles after a fetch grant: drain, then refetch at new address.
    mem_lat = 6;
    if_req = 1; if_addr = 32'h1100;
    push_issue(ID_IF, 32'h1100, 2'd2, 0);
    wait_mem_req("flush_mid_grant");
    tick();
    if_flush = 1; if_addr = 32'h1200;
    push_issue(ID_IF, 32'h1200, 2'd2, 0); push_resp(ID_IF, 32'hC3A5_84F1, 32'h1200);
    tick();
    if_flush = 0;
    tick();
    chk("drain_mem_req_held", 32'(mem_req), 1);
    chk("drain_mem_addr", mem_addr, 32'h1100);
    cyc = 0;
    while (!if_done && cyc < 100) begin tick(); cyc++; end
    if (!if_done) fail_now("flush_refetch_done");
    if_req = 0;
    repeat (2) tick();

    // Flush coinciding with mem_done of a fetch; a load waits behind it.
    mem_lat = 4;
    if_req = 1; if_addr = 32'h1300;
    push_issue(ID_IF, 32'h1300, 2'd2, 0);
    wait_mem_req("flush_done_grant");
    ld_req = 1; ld_addr = 32'h3004; ld_size = 2'd1;
    push_issue(ID_LD, 32'h3004, 2'd1, 0); push_resp(ID_LD, 32'h0000_A6F5, 0);
    repeat (3) tick();
    if_flush = 1; if_req = 0;
    tick();
    if_flush = 0;
    chk("flush_done_no_if_done", 32'(if_done), 0);
    cyc = 0;
    while (!ld_done && cyc < 100) begin tick(); cyc++; end
    if (!ld_done) fail_now("flush_done_load");
    ld_req = 0;
    repeat (2) tick();

    // Reset during a store in flight.
    mem_lat = 8;
    st_req = 1; st_addr = 32'h2020; st_data = 32'h5566_7788; st_size = 2'd2;
    push_issue(ID_ST, 32'h2020, 2'd2, 32'h5566_7788);
    wait_mem_req("reset_store_grant");
    repeat (2) tick();
    rst = 1; st_req = 0;
    tick();
    chk("rst_mid_mem_req", 32'(mem_req), 0);
    chk("rst_mid_st_done", 32'(st_done), 0);
    chk("rst_mid_ld_done", 32'(ld_done), 0);
    chk("rst_mid_if_done", 32'(if_done), 0);
    tick();
    rst = 0;
    repeat (10) tick();
    chk("post_rst_mem_req", 32'(mem_req), 0);

    chk("issue_queue_empty", 32'(issue_q.size()), 0);
    chk("resp_queue_empty", 32'(resp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-serial memory controller between three requesters: instruction fetch, load unit and store buffer.
- Sits between the fetch and LSB front-ends and the memory controller.
- Issues one transaction at a time to the controller, holds it until the controller reports completion, and routes the result back.
- Handles fetch flushes on branch mispredict and prevents fetch starvation under heavy load/store traffic.

Parameters:
- STARVE_LIMIT, 4, number of lost arbitrations with if_req pending after which fetch wins the next arbitration (legal 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address
- if_flush  in  1  pulse, discard the current or pending fetch
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched instruction
- if_addr_o  out  32  address belonging to if_data
- ld_req  in  1  load request, level
- ld_addr  in  32  load address
- ld_size  in  2  0=1B, 1=2B, 2=4B
- ld_done  out  1  one-cycle pulse
- ld_data  out  32  load data, zero-extended
- st_req  in  1  store request, level
- st_addr  in  32  store address
- st_data  in  32  store data, low bytes used
- st_size  in  2  as ld_size
- st_done  out  1  one-cycle pulse
- mem_req  out  1  transaction request to the controller
- mem_we  out  1  1=write
- mem_addr  out  32  transaction address
- mem_wdata  out  32  write data
- mem_size  out  2  transaction size
- mem_done  in  1  controller completion pulse
- mem_rdata  in  32  read data, valid with mem_done

Behaviour:
- Reset: synchronous, active-high on rst at the rising edge of clk. All outputs, the state and the starvation counter are cleared to 0. A transaction in flight is abandoned; the controller is reset by the same rst.
- State machine: IDLE, BUSY, RESP, DRAIN.
- Arbitration in IDLE uses this priority order:
  - fetch, if if_req and starve_cnt >= STARVE_LIMIT;
  - otherwise st_req;
  - otherwise ld_req;
  - otherwise if_req (with if_flush low).
- Grant registration: the winner's address, size and data are registered. At the next edge mem_req=1, mem_we=(winner is store), fetch size=2. State goes to BUSY. Latency is one cycle from request to mem_req.
- Request outputs are stable while mem_req=1. The requester's own inputs are not re-sampled while a grant is held.
- BUSY:
  - On mem_done: mem_req goes to 0.
  - The granted requester's done pulses for exactly one cycle at the next edge, with data registered: ld_data masked to size; if_data=mem_rdata; if_addr_o=granted address.
  - State goes to RESP.
- RESP: one turnaround cycle in which all requests are ignored, so requesters can drop req; then IDLE.
- Flush during a fetch grant:
  - if_flush in BUSY with a fetch granted → DRAIN. mem_req stays high until mem_done, then IDLE.
  - No if_done is produced in DRAIN.
  - if_flush coinciding with mem_done of a fetch: no if_done; go to IDLE.
- Flush in IDLE: fetch is excluded from that cycle's arbitration.
- Flush never affects load or store transactions.
- Starvation counter (4 bit):
  - +1 (saturating at 15) whenever an IDLE arbitration grants load or store while if_req=1.
  - Cleared on a fetch grant or on if_flush.
- Simultaneous store and load with starve_cnt < STARVE_LIMIT: store wins; load waits.
- mem_done while in IDLE or RESP: ignored (protocol error; assertion in the bench).
- Writes are never split or retried; controller back-pressure (io full) is absorbed by the controller delaying mem_done.

Optional Feature:
- MEM_ARB_PERF_EN: adds outputs perf_if_cnt, perf_ld_cnt, perf_st_cnt (32 bit each, count completed transactions per requester) and perf_stall_cnt (32 bit, counts cycles in which any req is high and the state is not IDLE). All wrap at 2^32 and are cleared by rst.
- Without the macro these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared defines: state encodings, size encodings (SIZE_B/H/W), requester ID codes (REQ_IF/LD/ST).
- One sub-module is natural: mem_arb_pick, a combinational priority picker with starvation override, taking the three reqs, flush and starve flag and returning a one-hot grant. Everything else stays in mem_arbiter.

Test Plan:
- Fetch only: if_req=1, if_addr=0x1000; controller returns 0x00000013 after 9 cycles → mem_req on the next cycle, if_done one pulse, if_data=0x13, if_addr_o=0x1000.
- Load and store asserted together: st 0x2000 ← 0xAABBCCDD size 2, ld 0x3000 size 0 → store issued first (mem_we=1); then load; ld_data=0x000000XX, upper bytes zero.
- Starvation with STARVE_LIMIT=2: continuous ld_req plus if_req → two loads, then fetch granted on the third arbitration; starve_cnt returns to 0.
- Flush mid-fetch: if_flush two cycles after the fetch grant → mem_req held until mem_done, no if_done, next arbitration at the new if_addr.
- Flush coinciding with mem_done → no if_done; a load waiting behind the fetch is granted after RESP→IDLE.
- Reset mid-transaction: rst during BUSY of a store → next cycle mem_req=0, all done=0, state IDLE, no st_done.
